vdecode_pipe: RTL and testbench
===============================

Name: vdecode_pipe

Overview:
Registered, handshaked instruction decode stage. It generalises the single-cycle combinational decoder to a pipelined stage with parametrised immediate extension, valid/ready flow control and load-use hazard stalling. It sits between the instruction fetch stage and the register-file/ALU stage of the pipelined VMIPS core. It emits one decoded control bundle per accepted instruction with 1-cycle latency.

Parameters:
DATA_W, 32, width of the extended immediate output (must be >= 16)
CNT_W, 16, width of the statistics counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
inst  in  32  instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts the bundle
reg_dst  out  5  destination register (rd for R-type, rt for I-type, 0 for sw/illegal)
reg_s  out  5  inst[25:21]
reg_t  out  5  inst[20:16]
imm_ext  out  DATA_W  extended inst[15:0]
reg_write, mem_read, mem_write, memtoreg  out  1 each  control strobes
alu_op  out  3  ALU function
alu_src  out  2  00 register, 01 sign-extended imm, 10 zero-extended imm
illegal  out  1  unknown opcode or funct
stat_inst, stat_illegal, stat_stall  out  CNT_W each  counters (optional feature)

Behaviour:
- Clock: one clock `clk`. Reset: `rst`, synchronous, active-high. On reset: out_valid=0, all bundle registers=0, counters=0.
- Decode, opcode inst[31:26]:
  - 000000 R-type: funct inst[5:0] selects alu_op: 100000 add=000, 100010 sub=001, 100100 and=010, 100101 or=011, 101010 slt=100. reg_write=1, alu_src=00, reg_dst=rd.
  - 001000 addi: alu_op 000, alu_src 01, reg_write=1.
  - 001100 andi: alu_op 010, alu_src 10, reg_write=1.
  - 100011 lw: alu_op 000, alu_src 01, mem_read=1, memtoreg=1, reg_write=1.
  - 101011 sw: alu_op 000, alu_src 01, mem_write=1, reg_dst=0.
  - Any other opcode, or an R-type with an unlisted funct: illegal=1; all strobes, alu_op and alu_src are 0. The bundle is still emitted.
- imm_ext: sign extension of inst[15:0] to DATA_W, except andi, which zero-extends.
- Output register:
  - Loads when in_valid && in_ready.
  - out_valid is set on load. It is cleared when out_ready is high and no new load occurs in the same cycle.
  - Bundle is held stable while out_valid && !out_ready.
- in_ready = (!out_valid || out_ready) && !hazard.
- Hazard (load-use):
  - Condition: out_valid && mem_read && reg_t != 0, and the incoming instruction reads reg_t.
  - Reading reg_t means: inst rs equals it (any opcode except illegal), or inst rt equals it (R-type or sw only).
  - During a hazard the stage inserts exactly one bubble. When out_ready is high the load drains, out_valid=0 the next cycle, and the held instruction is accepted that cycle.
- Simultaneous drain and load: out_valid stays 1 and the new bundle replaces the old one. There is no bubble when there is no hazard.
- Latency: 1 cycle from acceptance to out_valid. Throughput: 1 instruction per cycle with no hazards.
- Reset asserted mid-stall: reset wins. out_valid=0 next cycle, and any pending instruction is dropped.
- in_valid low: nothing loads, and out_valid drains normally.

Optional Feature:
DECODE_STATS_EN
- Defined: counters increment on these events, each saturating at 2^CNT_W-1 with no wrap:
  - stat_inst: +1 per accepted instruction.
  - stat_illegal: +1 per accepted illegal instruction.
  - stat_stall: +1 per cycle with in_valid && hazard.
- Undefined: all three outputs are tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=1 after release, counters 0.
- Stream 0x00221820 (add $3,$1,$2), then 0x2005FFFF (addi $5,$0,-1), with out_ready=1 -> first cycle: reg_dst=3, alu_op=000, alu_src=00, reg_write=1. Second cycle: reg_dst=5, imm_ext=0xFFFFFFFF, alu_src=01. No bubbles.
- 0x3006FFFF (andi) -> imm_ext=0x0000FFFF, alu_src=10, alu_op=010.
- 0x8C220004 (lw $2,4($1)), then 0x00411820 (add reads $2) -> in_ready=0 for one cycle, one bubble cycle with out_valid=0, add emitted on the third cycle. stat_stall=1 when DECODE_STATS_EN is defined.
- Backpressure: out_ready=0 for 3 cycles while holding lw -> bundle stable, in_ready=0. On release, data is accepted in order with no loss or duplication.
- 0xFC000000 -> illegal=1, all strobes 0. stat_illegal=1 with DECODE_STATS_EN defined; stat_illegal=0 without it.

Source files
------------

// File: rtl/vdecode_pipe.sv
// Registered instruction decode stage: opcode/funct decode, immediate extension, load-use stall.
// Latency: 1 cycle from acceptance (in_valid && in_ready) to out_valid.
// Backpressure: bundle held while out_valid && !out_ready; in_ready also drops for one bubble on a load-use hazard.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/inst   instruction handshake from fetch
//   out_valid/out_ready      decoded bundle handshake to the register-file/ALU stage
//   reg_dst, reg_s, reg_t    destination / source register numbers
//   imm_ext                  inst[15:0] extended to DATA_W (zero-extended for andi)
//   reg_write, mem_read, mem_write, memtoreg, alu_op, alu_src, illegal   control bundle
//   stat_inst, stat_illegal, stat_stall   saturating event counters
//
// Build option: define DECODE_STATS_EN to build the statistics counters; without it the
// stat_* outputs are constant zero and no counter flops exist.
module vdecode_pipe #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        reg_dst,
    output logic [4:0]        reg_s,
    output logic [4:0]        reg_t,
    output logic [DATA_W-1:0] imm_ext,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              memtoreg,
    output logic [2:0]        alu_op,
    output logic [1:0]        alu_src,
    output logic              illegal,
    output logic [CNT_W-1:0]  stat_inst,
    output logic [CNT_W-1:0]  stat_illegal,
    output logic [CNT_W-1:0]  stat_stall
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;

    localparam logic [1:0] SRC_REG  = 2'b00;
    localparam logic [1:0] SRC_SEXT = 2'b01;
    localparam logic [1:0] SRC_ZEXT = 2'b10;

    // Decoded control bundle, carried as one packed word through the output register.
    typedef struct packed {
        logic [4:0]        reg_dst;
        logic [4:0]        reg_s;
        logic [4:0]        reg_t;
        logic [DATA_W-1:0] imm_ext;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              memtoreg;
        logic [2:0]        alu_op;
        logic [1:0]        alu_src;
        logic              illegal;
    } bundle_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [2:0]        rtype_alu_op;
    logic              rtype_ok;
    bundle_t           dec;
    logic              dec_reads_rs;
    logic              dec_reads_rt;

    assign opcode   = inst[31:26];
    assign funct    = inst[5:0];
    assign imm_sext = DATA_W'($signed(inst[15:0]));
    assign imm_zext = DATA_W'(inst[15:0]);

    // R-type funct lookup; rtype_ok low marks an unlisted funct.
    always_comb begin
        rtype_alu_op = ALU_ADD;
        rtype_ok     = 1'b1;
        case (funct)
            FN_ADD:  rtype_alu_op = ALU_ADD;
            FN_SUB:  rtype_alu_op = ALU_SUB;
            FN_AND:  rtype_alu_op = ALU_AND;
            FN_OR:   rtype_alu_op = ALU_OR;
            FN_SLT:  rtype_alu_op = ALU_SLT;
            default: rtype_ok     = 1'b0;
        endcase
    end

    always_comb begin
        // Register fields pass through unconditionally; everything else
        // defaults to the illegal/no-op encoding and is filled in per opcode.
        dec         = '0;
        dec.reg_s   = inst[25:21];
        dec.reg_t   = inst[20:16];
        dec.imm_ext = imm_sext;
        dec.illegal = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                if (rtype_ok) begin
                    dec.reg_dst   = inst[15:11];
                    dec.reg_write = 1'b1;
                    dec.alu_op    = rtype_alu_op;
                    dec.alu_src   = SRC_REG;
                end else begin
                    dec.illegal   = 1'b1;
                end
            end
            OP_ADDI: begin
                dec.reg_dst   = inst[20:16];
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = SRC_SEXT;
            end
            OP_ANDI: begin
                dec.reg_dst   = inst[20:16];
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_AND;
                dec.alu_src   = SRC_ZEXT;
                dec.imm_ext   = imm_zext;
            end
            OP_LW: begin
                dec.reg_dst   = inst[20:16];
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.memtoreg  = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = SRC_SEXT;
            end
            OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = SRC_SEXT;
            end
            default: begin
                dec.illegal   = 1'b1;
            end
        endcase
    end

    // Which source registers the incoming instruction actually consumes.
    // I-type ALU ops and lw write rt rather than read it, so only R-type
    // and sw count rt as a source. Illegal words read nothing.
    assign dec_reads_rs = !dec.illegal;
    assign dec_reads_rt = !dec.illegal && ((opcode == OP_RTYPE) || (opcode == OP_SW));

    // ------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------
    bundle_t bundle_q, bundle_d;
    logic    out_valid_q, out_valid_d;
    logic    load_pending;
    logic    hazard;
    logic    accept;

    // A load sitting in the output register whose result the incoming
    // instruction needs. Holding off acceptance until the load has drained
    // yields exactly one bubble: the cycle after the drain, out_valid is low
    // so the hazard term vanishes and the held word is taken.
    assign load_pending = out_valid_q && bundle_q.mem_read && (bundle_q.reg_t != 5'd0);
    assign hazard       = load_pending &&
                          ((dec_reads_rs && (inst[25:21] == bundle_q.reg_t)) ||
                           (dec_reads_rt && (inst[20:16] == bundle_q.reg_t)));

    assign in_ready = (!out_valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            // Covers simultaneous drain and load: the new bundle replaces
            // the old one and out_valid stays high.
            bundle_d    = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign reg_dst   = bundle_q.reg_dst;
    assign reg_s     = bundle_q.reg_s;
    assign reg_t     = bundle_q.reg_t;
    assign imm_ext   = bundle_q.imm_ext;
    assign reg_write = bundle_q.reg_write;
    assign mem_read  = bundle_q.mem_read;
    assign mem_write = bundle_q.mem_write;
    assign memtoreg  = bundle_q.memtoreg;
    assign alu_op    = bundle_q.alu_op;
    assign alu_src   = bundle_q.alu_src;
    assign illegal   = bundle_q.illegal;

    // ------------------------------------------------------------------
    // Statistics counters
    // ------------------------------------------------------------------
`ifdef DECODE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stat_inst_q,    stat_inst_d;
    logic [CNT_W-1:0] stat_illegal_q, stat_illegal_d;
    logic [CNT_W-1:0] stat_stall_q,   stat_stall_d;

    // Each counter sticks at all-ones rather than wrapping.
    always_comb begin
        stat_inst_d    = stat_inst_q;
        stat_illegal_d = stat_illegal_q;
        stat_stall_d   = stat_stall_q;
        if (accept && (stat_inst_q != CNT_MAX)) begin
            stat_inst_d = stat_inst_q + CNT_W'(1);
        end
        if (accept && dec.illegal && (stat_illegal_q != CNT_MAX)) begin
            stat_illegal_d = stat_illegal_q + CNT_W'(1);
        end
        if (in_valid && hazard && (stat_stall_q != CNT_MAX)) begin
            stat_stall_d = stat_stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_inst_q    <= '0;
            stat_illegal_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            stat_inst_q    <= stat_inst_d;
            stat_illegal_q <= stat_illegal_d;
            stat_stall_q   <= stat_stall_d;
        end
    end

    assign stat_inst    = stat_inst_q;
    assign stat_illegal = stat_illegal_q;
    assign stat_stall   = stat_stall_q;
`else
    assign stat_inst    = '0;
    assign stat_illegal = '0;
    assign stat_stall   = '0;
`endif

endmodule

// File: tb/tb_vdecode_pipe.sv
// Bench for vdecode_pipe: directed sequences then randomized traffic.
// Expected bundles are queued on acceptance and checked by an independent output monitor.
// out_ready is driven always-high, held low, or randomized per cycle.
module tb_vdecode_pipe;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        reg_dst, reg_s, reg_t;
    logic [DATA_W-1:0] imm_ext;
    logic              reg_write, mem_read, mem_write, memtoreg;
    logic [2:0]        alu_op;
    logic [1:0]        alu_src;
    logic              illegal;
    logic [CNT_W-1:0]  stat_inst, stat_illegal, stat_stall;

    vdecode_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_dst(reg_dst), .reg_s(reg_s), .reg_t(reg_t), .imm_ext(imm_ext),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .memtoreg(memtoreg), .alu_op(alu_op), .alu_src(alu_src), .illegal(illegal),
        .stat_inst(stat_inst), .stat_illegal(stat_illegal), .stat_stall(stat_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  dst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [2:0]  aop;
        logic [1:0]  asrc;
        logic        ill;
    } bnd_t;

    int   total = 0;
    int   bad   = 0;
    bnd_t sbq[$];
    int   ordy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    // Reference model state: what the stage should be presenting.
    bit   mv = 0;
    bnd_t last = '0;
    int   c_inst = 0, c_ill = 0, c_stall = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decoder written from the instruction table.
    function automatic bnd_t ref_dec(input logic [31:0] w);
        bnd_t       b;
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] ftab [5];
        ftab  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};   // add sub and or slt
        op    = w[31:26];
        fn    = w[5:0];
        b     = '0;
        b.rs  = w[25:21];
        b.rt  = w[20:16];
        b.imm = {{16{w[15]}}, w[15:0]};
        b.ill = 1'b1;
        if (op == 6'd0) begin
            for (int i = 0; i < 5; i++) begin
                if (fn == ftab[i]) begin
                    b.ill = 1'b0; b.rw = 1'b1; b.aop = 3'(i); b.dst = w[15:11];
                end
            end
        end else if (op == 6'd8) begin
            b.ill = 1'b0; b.rw = 1'b1; b.asrc = 2'd1; b.dst = w[20:16];
        end else if (op == 6'd12) begin
            b.ill = 1'b0; b.rw = 1'b1; b.aop = 3'd2; b.asrc = 2'd2; b.dst = w[20:16];
            b.imm = {16'h0000, w[15:0]};
        end else if (op == 6'd35) begin
            b.ill = 1'b0; b.rw = 1'b1; b.mr = 1'b1; b.m2r = 1'b1; b.asrc = 2'd1; b.dst = w[20:16];
        end else if (op == 6'd43) begin
            b.ill = 1'b0; b.mw = 1'b1; b.asrc = 2'd1;
        end
        return b;
    endfunction

    function automatic bit reads(input logic [31:0] w, input logic [4:0] r);
        bnd_t b;
        b = ref_dec(w);
        if (b.ill) return 1'b0;
        if (w[25:21] == r) return 1'b1;
        if (((w[31:26] == 6'd0) || (w[31:26] == 6'd43)) && (w[20:16] == r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0]  op;
        logic [15:0] low;
        logic [4:0]  rs, rt;
        logic [5:0]  ftab [5];
        int          k;
        ftab = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        rs   = 5'($urandom_range(0, 3));
        rt   = 5'($urandom_range(0, 3));
        low  = 16'($urandom);
        k    = $urandom_range(0, 9);
        case (k)
            0, 1: begin op = 6'd0; low[5:0] = ftab[$urandom_range(0, 4)]; end
            2:    op = 6'd0;
            3:    op = 6'd8;
            4:    op = 6'd12;
            5, 6: op = 6'd35;
            7:    op = 6'd43;
            default: op = 6'($urandom);
        endcase
        return {op, rs, rt, low};
    endfunction

    // out_ready driver, offset from the main stimulus so mode changes settle first.
    initial out_ready = 1'b1;
    always begin
        @(posedge clk);
        #2;
        case (ordy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Reference model: checks out_valid, in_ready, counters; queues expected bundles.
    always @(negedge clk) begin : model
        bnd_t d;
        bit   hz;
        bit   er;
        if (rst) begin
            mv = 0; last = '0; sbq.delete();
            c_inst = 0; c_ill = 0; c_stall = 0;
        end else begin
            chk("out_valid", 128'(out_valid), 128'(mv));
            hz = mv && last.mr && (last.rt != 5'd0) && reads(inst, last.rt);
            er = (!mv || out_ready) && !hz;
            if (in_valid) chk("in_ready", 128'(in_ready), 128'(er));
`ifdef DECODE_STATS_EN
            chk("stat_inst",    128'(stat_inst),    128'(c_inst));
            chk("stat_illegal", 128'(stat_illegal), 128'(c_ill));
            chk("stat_stall",   128'(stat_stall),   128'(c_stall));
`else
            chk("stat_inst",    128'(stat_inst),    128'(0));
            chk("stat_illegal", 128'(stat_illegal), 128'(0));
            chk("stat_stall",   128'(stat_stall),   128'(0));
`endif
            if (in_valid && er) begin
                d = ref_dec(inst);
                sbq.push_back(d);
                mv = 1; last = d;
                c_inst++;
                if (d.ill) c_ill++;
            end else if (out_ready) begin
                mv = 0;
            end
            if (in_valid && hz) c_stall++;
        end
    end

    // Output monitor: every valid cycle must show the head of the scoreboard.
    always @(negedge clk) begin : monitor
        bnd_t act;
        if (!rst && out_valid) begin
            act = '{dst: reg_dst, rs: reg_s, rt: reg_t, imm: imm_ext, rw: reg_write,
                    mr: mem_read, mw: mem_write, m2r: memtoreg, aop: alu_op,
                    asrc: alu_src, ill: illegal};
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out: got bundle %0h with nothing expected at %0t", act, $time);
            end else begin
                chk("bundle", 128'(act), 128'(sbq[0]));
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until the stage takes it.
    task automatic issue(input logic [31:0] w);
        int n;
        n        = 0;
        in_valid = 1'b1;
        inst     = w;
        forever begin
            @(negedge clk);
            n++;
            if (in_ready === 1'b1) break;
            if (n >= 100) begin
                total++; bad++;
                $display("FAIL accept_timeout: inst %h not taken after %0d cycles, wanted acceptance", w, n);
                break;
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        inst     = 32'h0022_1820;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back stream, andi, load-use stall.
        issue(32'h0022_1820);      // add $3,$1,$2
        issue(32'h2005_FFFF);      // addi $5,$0,-1
        issue(32'h3006_FFFF);      // andi
        issue(32'h8C22_0004);      // lw $2,4($1)
        issue(32'h0041_1820);      // add reads $2 -> one bubble

        // Backpressure with a load held in the output register.
        issue(32'h8C22_0004);
        ordy_mode = 2;
        in_valid  = 1'b1;
        inst      = 32'h00A6_3820; // add $7,$5,$6 (independent)
        repeat (3) step();
        ordy_mode = 0;
        issue(32'h00A6_3820);
        issue(32'hFC00_0000);      // illegal opcode
        issue(32'h0022_183F);      // R-type, unlisted funct

        // Reset while a dependent word is stalled behind a held load.
        issue(32'h8C22_0004);
        ordy_mode = 2;
        in_valid  = 1'b1;
        inst      = 32'h0041_1820;
        step();
        step();
        rst       = 1'b1;
        in_valid  = 1'b0;
        ordy_mode = 0;
        step();
        rst = 1'b0;
        step();

        // Randomized traffic with random backpressure.
        ordy_mode = 1;
        for (int i = 0; i < 1200; i++) begin
            issue(rand_inst());
            if ($urandom_range(0, 3) == 0) step();
        end

        ordy_mode = 0;
        repeat (5) step();
        chk("drain_empty", 128'(sbq.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
